fibonacci_seq: RTL and testbench

//  Parametrised Fibonacci-style sequence generator with loadable seeds, valid/ready output,

---
 rtl/fibonacci_pkg.sv | 32 +++
 rtl/fibonacci_step.sv | 60 ++++++
 rtl/fibonacci_seq.sv | 144 ++++++++++++++
 tb/tb_fibonacci_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_pkg.sv
// ----------------------------------------------------------------------------
// fibonacci_pkg: shared mode/state encodings for the Fibonacci term generator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fibonacci_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_STOP    = 2'b01,
    MODE_RESTART = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The spare encoding 2'b11 behaves as WRAP.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_mode = MODE_STOP;
      2'b10:   decode_mode = MODE_RESTART;
      default: decode_mode = MODE_WRAP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fibonacci_step.sv
// ----------------------------------------------------------------------------
// fibonacci_step: a+b with carry and overflow-policy mux for the next a/b/last
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fibonacci_step
  import fibonacci_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] seed0_i,
  input  logic [WIDTH-1:0] seed1_i,
  input  logic             last_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             last_o,
  output logic             ovf_set_o,
  output logic             stop_o,
  output logic             restart_o
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    a_o       = b_i;
    b_o       = sum[WIDTH-1:0];
    last_o    = last_i;
    ovf_set_o = 1'b0;
    stop_o    = 1'b0;
    restart_o = 1'b0;
    if (last_i) begin
      if (mode_i == MODE_STOP) begin
        a_o    = a_i;
        b_o    = b_i;
        stop_o = 1'b1;
      end else if (mode_i == MODE_RESTART) begin
        a_o       = seed0_i;
        b_o       = seed1_i;
        last_o    = 1'b0;
        restart_o = 1'b1;
      end
    end else if (sum[WIDTH]) begin
      ovf_set_o = 1'b1;
      // Non-wrapping policies present the last in-range term once more before acting.
      if (mode_i == MODE_STOP || mode_i == MODE_RESTART) begin
        b_o    = b_i;
        last_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fibonacci_seq.sv
// ----------------------------------------------------------------------------
// fibonacci_seq: loadable Fibonacci-style term generator with valid/ready output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fibonacci_seq
  import fibonacci_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = 16,
  parameter int MAX_TERMS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_seed0,
  input  logic [WIDTH-1:0] cfg_seed1,
  input  logic [1:0]       cfg_mode,
  input  logic             run,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] value,
  output logic [IDX_W-1:0] index,
  output logic             overflow,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = (MAX_TERMS == 0) ? '0 : IDX_W'(MAX_TERMS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] seed0_q, seed0_d, seed1_q, seed1_d;
  mode_e            mode_q, mode_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             ovf_q, ovf_d, last_q, last_d;

  logic             xfer, hit_max, loadable;
  logic [WIDTH-1:0] step_a, step_b;
  logic             step_last, step_ovf, step_stop, step_restart;

  assign xfer     = (state_q == ST_RUN) && ready;
  assign hit_max  = (MAX_TERMS != 0) && (index_q == LAST_IDX);
  assign loadable = cfg_load && (state_q == ST_IDLE || state_q == ST_DONE);

  fibonacci_step #(.WIDTH(WIDTH)) u_step (
    .a_i       (a_q),
    .b_i       (b_q),
    .seed0_i   (seed0_q),
    .seed1_i   (seed1_q),
    .last_i    (last_q),
    .mode_i    (mode_q),
    .a_o       (step_a),
    .b_o       (step_b),
    .last_o    (step_last),
    .ovf_set_o (step_ovf),
    .stop_o    (step_stop),
    .restart_o (step_restart)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!cfg_load && run) state_d = ST_RUN;
      ST_RUN: begin
        if (xfer) begin
          if (hit_max || step_stop) state_d = ST_DONE;
          else if (!run)            state_d = ST_IDLE;
        end
      end
      ST_DONE: if (cfg_load) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid    = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    value    = a_q;
    index    = index_q;
    overflow = ovf_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    seed0_d = seed0_q;
    seed1_d = seed1_q;
    mode_d  = mode_q;
    index_d = index_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    if (loadable) begin
      a_d     = cfg_seed0;
      b_d     = cfg_seed1;
      seed0_d = cfg_seed0;
      seed1_d = cfg_seed1;
      mode_d  = decode_mode(cfg_mode);
      index_d = '0;
      ovf_d   = 1'b0;
      last_d  = 1'b0;
    end else if (xfer) begin
      index_d = index_q + IDX_W'(1);
      // Term limit takes precedence: a/b freeze on the final transfer.
      if (!hit_max) begin
        a_d    = step_a;
        b_d    = step_b;
        last_d = step_last;
        if (step_ovf)     ovf_d   = 1'b1;
        if (step_restart) index_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      seed0_q <= '0;
      seed1_q <= WIDTH'(1);
      mode_q  <= MODE_WRAP;
      index_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      seed0_q <= seed0_d;
      seed1_q <= seed1_d;
      mode_q  <= mode_d;
      index_q <= index_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fibonacci_seq.sv
// ----------------------------------------------------------------------------
// tb_fibonacci_seq: scoreboard bench for fibonacci_seq (WIDTH=8, IDX_W=8)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fibonacci_seq;

  typedef struct packed {
    logic [7:0] val;
    logic [7:0] idx;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [7:0]       s0;
    logic [7:0]       s1;
    logic [7:0]       n;
    logic [15:0][7:0] vals;
    logic [15:0][7:0] idxs;
    logic [15:0]      ovfs;
    logic             exp_ovf;
    logic             exp_done;
  } vec_t;

  logic       clk, reset, cfg_load, run, ready, sel, mon_en;
  logic [7:0] cfg_seed0, cfg_seed1;
  logic [1:0] cfg_mode;
  logic       valid0, overflow0, done0, valid5, overflow5, done5;
  logic [7:0] value0, index0, value5, index5;
  logic       valid_s, overflow_s;
  logic [7:0] value_s, index_s;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic       prev_hold;
  logic [7:0] prev_val, prev_idx;

  fibonacci_seq #(.WIDTH(8), .IDX_W(8), .MAX_TERMS(0)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_seed0(cfg_seed0),
    .cfg_seed1(cfg_seed1), .cfg_mode(cfg_mode), .run(run), .ready(ready),
    .valid(valid0), .value(value0), .index(index0), .overflow(overflow0), .done(done0)
  );

  fibonacci_seq #(.WIDTH(8), .IDX_W(8), .MAX_TERMS(5)) dut5 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_seed0(cfg_seed0),
    .cfg_seed1(cfg_seed1), .cfg_mode(cfg_mode), .run(run), .ready(ready),
    .valid(valid5), .value(value5), .index(index5), .overflow(overflow5), .done(done5)
  );

  assign valid_s    = sel ? valid5    : valid0;
  assign value_s    = sel ? value5    : value0;
  assign index_s    = sel ? index5    : index0;
  assign overflow_s = sel ? overflow5 : overflow0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) begin
        checks++;
        if (valid_s !== 1'b1 || value_s !== prev_val || index_s !== prev_idx) begin
          failures++;
          $display("FAIL hold_stable valid=%0d value=%0d index=%0d required valid=1 value=%0d index=%0d",
                   valid_s, value_s, index_s, prev_val, prev_idx);
        end
      end
      prev_hold = valid_s && !ready;
      prev_val  = value_s;
      prev_idx  = index_s;
      if (valid_s && ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_term value=%0d index=%0d required no term", value_s, index_s);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (value_s !== e.val || index_s !== e.idx || overflow_s !== e.ovf) begin
            failures++;
            $display("FAIL term value/index/ovf=%0d/%0d/%0d required %0d/%0d/%0d",
                     value_s, index_s, overflow_s, e.val, e.idx, e.ovf);
          end
        end
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] v, input logic [7:0] i, input logic o);
    exp_t e;
    e.val = v;
    e.idx = i;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b0; ready = 1'b0; cfg_load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] m, input logic [7:0] s0, input logic [7:0] s1);
    cfg_load = 1'b1; cfg_mode = m; cfg_seed0 = s0; cfg_seed1 = s1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  // Drive run/ready until the scoreboard drains; drop run while the final term is on offer.
  task automatic stream(input int budget, input bit toggle, input bit hold_run);
    int cyc;
    cyc   = 0;
    run   = 1'b1;
    ready = 1'b1;
    while (sb.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (toggle) ready = ~ready;
      if (!hold_run && sb.size() == 1 && valid_s) run = 1'b0;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  logic [7:0] fib [15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
                           8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
  logic [7:0] lucas [5] = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd7};
  vec_t vecs [4];

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_seed0 = '0; cfg_seed1 = '0; cfg_mode = '0;
    run = 1'b0; ready = 1'b0; sel = 1'b0; mon_en = 1'b0;

    for (int k = 0; k < 4; k++) begin
      vecs[k] = '0;
      vecs[k].s1 = 8'd1;
      vecs[k].exp_ovf = 1'b1;
      for (int i = 0; i < 16; i++) begin
        vecs[k].vals[i] = (i < 15) ? fib[i] : 8'd0;
        vecs[k].idxs[i] = 8'(i);
        vecs[k].ovfs[i] = (i >= 13);
      end
    end
    vecs[0].mode = 2'b00; vecs[0].n = 8'd15;
    vecs[1].mode = 2'b01; vecs[1].n = 8'd14; vecs[1].exp_done = 1'b1;
    vecs[2].mode = 2'b10; vecs[2].n = 8'd16;
    vecs[2].vals[14] = 8'd0; vecs[2].idxs[14] = 8'd0;
    vecs[2].vals[15] = 8'd1; vecs[2].idxs[15] = 8'd1;
    vecs[3].mode = 2'b11; vecs[3].n = 8'd15;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(valid0), 0);
    chk("reset_value", 32'(value0), 0);
    chk("reset_index", 32'(index0), 0);
    chk("reset_overflow", 32'(overflow0), 0);
    chk("reset_done", 32'(done0), 0);
    reset = 1'b0;

    for (int k = 0; k < 4; k++) begin
      do_reset();
      load(vecs[k].mode, vecs[k].s0, vecs[k].s1);
      for (int i = 0; i < int'(vecs[k].n); i++)
        push(vecs[k].vals[i], vecs[k].idxs[i], vecs[k].ovfs[i]);
      mon_en = 1'b1;
      stream(200, 1'b0, 1'b0);
      @(posedge clk); #1;
      run = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_overflow", k), 32'(overflow0), 32'(vecs[k].exp_ovf));
      chk($sformatf("vec%0d_done", k), 32'(done0), 32'(vecs[k].exp_done));
      chk($sformatf("vec%0d_valid_end", k), 32'(valid0), 0);
      mon_en = 1'b0;
    end

    // Ready toggling every cycle; run drops while the last wanted term is on offer.
    do_reset();
    load(2'b00, 8'd0, 8'd1);
    for (int i = 0; i < 10; i++) push(fib[i], 8'(i), 1'b0);
    mon_en = 1'b1;
    stream(200, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("toggle_idle_valid", 32'(valid0), 0);
    chk("toggle_idle_index", 32'(index0), 10);
    mon_en = 1'b0;

    // Reset while index 6 is on offer.
    do_reset();
    for (int i = 0; i < 6; i++) push(fib[i], 8'(i), 1'b0);
    mon_en = 1'b1;
    stream(100, 1'b0, 1'b1);
    mon_en = 1'b0;
    chk("pre_reset_index", 32'(index0), 6);
    chk("pre_reset_value", 32'(value0), 8);
    ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_reset_valid", 32'(valid0), 0);
    chk("post_reset_index", 32'(index0), 0);
    chk("post_reset_overflow", 32'(overflow0), 0);
    for (int i = 0; i < 3; i++) push(fib[i], 8'(i), 1'b0);
    mon_en = 1'b1;
    stream(50, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;

    // Lucas seeds with a five-term limit; run held high into DONE.
    sel = 1'b1;
    do_reset();
    load(2'b00, 8'd2, 8'd1);
    for (int i = 0; i < 5; i++) push(lucas[i], 8'(i), 1'b0);
    mon_en = 1'b1;
    stream(100, 1'b0, 1'b1);
    chk("lucas_done", 32'(done5), 1);
    chk("lucas_valid_done", 32'(valid5), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("lucas_done_held", 32'(done5), 1);
    run = 1'b0;
    load(2'b00, 8'd2, 8'd1);
    chk("lucas_reload_done", 32'(done5), 0);
    chk("lucas_reload_index", 32'(index5), 0);
    chk("lucas_reload_valid", 32'(valid5), 0);
    push(8'd2, 8'd0, 1'b0);
    stream(50, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
